seg7_scan_decoder: RTL and testbench

//   Reads a multiplexed, active-low 7-segment display bus (anodes + cathodes)
//   and recovers the decimal digit shown on each position. It is the receiving
//   end of the BCD-to-7-segment decode path and is used for display loopback

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_pattern_to_bcd.sv | 42 ++++
 rtl/seg7_scan_decoder.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared 7-segment definitions for the encode and decode paths.
//               Patterns are active-high, bit order gfedcba (bit0 = a).
//               Contents:
//                 BCD_W, SEG_W    digit and pattern widths
//                 SEG_0..SEG_9    canonical digit patterns
//                 SEG_7_ALT       7 drawn with segment f lit
//                 SEG_9_ALT       9 drawn without segment d
//                 SEG_BLANK       all segments off
//                 seg7_decode_t   {legal, blank, value} decode result
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_7_ALT = 7'h27;
    localparam logic [SEG_W-1:0] SEG_9_ALT = 7'h67;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic             legal;   // pattern is one of the decimal glyphs
        logic             blank;   // pattern is all segments off
        logic [BCD_W-1:0] value;   // decimal value, meaningful only when legal
    } seg7_decode_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_pattern_to_bcd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_to_bcd
// Description : Combinational 7-segment pattern to BCD decoder.
//               Ports:
//                 i_pattern  in   7   active-high gfedcba pattern
//                 o_decode   out  6   {legal, blank, value[3:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] i_pattern,
    output seg7_decode_t     o_decode
);

    always_comb begin
        o_decode.legal = 1'b1;
        o_decode.blank = 1'b0;
        o_decode.value = '0;
        case (i_pattern)
            SEG_0:            o_decode.value = BCD_W'(0);
            SEG_1:            o_decode.value = BCD_W'(1);
            SEG_2:            o_decode.value = BCD_W'(2);
            SEG_3:            o_decode.value = BCD_W'(3);
            SEG_4:            o_decode.value = BCD_W'(4);
            SEG_5:            o_decode.value = BCD_W'(5);
            SEG_6:            o_decode.value = BCD_W'(6);
            SEG_7, SEG_7_ALT: o_decode.value = BCD_W'(7);
            SEG_8:            o_decode.value = BCD_W'(8);
            SEG_9, SEG_9_ALT: o_decode.value = BCD_W'(9);
            SEG_BLANK: begin
                o_decode.legal = 1'b0;
                o_decode.blank = 1'b1;
            end
            default:          o_decode.legal = 1'b0;
        endcase
    end

endmodule : seg7_pattern_to_bcd
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Recovers the decimal digits shown on a multiplexed, active-low
//               7-segment bus. Synchronises the bus, waits for a stable sample,
//               decodes the lit digit and flags completed scan frames.
//               Ports:
//                 clk          in   1             system clock
//                 reset        in   1             async active-high reset
//                 an_n         in   NUM_DIGITS    anode enables, active low
//                 seg_n        in   7             cathodes, active low, a=bit0
//                 digit_val    out  4*NUM_DIGITS  digit i at [4i+3:4i]
//                 digit_valid  out  NUM_DIGITS    digit i holds a legal 0-9
//                 digit_err    out  NUM_DIGITS    last capture illegal, non-blank
//                 frame_done   out  1             every digit captured (pulse)
//                 an_conflict  out  1             stable multi-anode sample (pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_DIGITS-1:0]       an_n,
    input  logic [SEG_W-1:0]            seg_n,
    output logic [BCD_W*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]       digit_valid,
    output logic [NUM_DIGITS-1:0]       digit_err,
    output logic                        frame_done,
    output logic                        an_conflict
);

    localparam int                     c_CNT_W   = 8;
    localparam logic [c_CNT_W-1:0]     c_CNT_MAX = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0]     c_CNT_PRE = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0]  c_AN_ONE  = NUM_DIGITS'(1);

    // Two-flop synchronisers plus one history stage for change detection.
    logic [NUM_DIGITS-1:0]       r_an_s1, r_an_s2, r_an_prev;
    logic [SEG_W-1:0]            r_seg_s1, r_seg_s2, r_seg_prev;
    logic [c_CNT_W-1:0]          r_stable_cnt;

    logic [BCD_W*NUM_DIGITS-1:0] r_digit_val;
    logic [NUM_DIGITS-1:0]       r_digit_valid, r_digit_err, r_mask;
    logic                        r_frame_done, r_an_conflict;

    logic                        w_changed, w_capture;
    logic [NUM_DIGITS-1:0]       w_an_act, w_mask_next;
    logic                        w_any_an, w_multi_an;
    seg7_decode_t                w_dec;

    assign w_changed = ({r_an_s2, r_seg_s2} != {r_an_prev, r_seg_prev});

    // The capture is taken on the edge where the counter steps onto
    // STABLE_CYCLES, so it fires once per stable period and the result is
    // registered alongside the counter.
    assign w_capture = !w_changed && (r_stable_cnt == c_CNT_PRE);

    assign w_an_act   = ~r_an_s2;
    assign w_any_an   = |w_an_act;
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_multi_an = (w_an_act & (w_an_act - c_AN_ONE)) != '0;
    assign w_mask_next = r_mask | w_an_act;

    seg7_pattern_to_bcd u_pattern_to_bcd (
        .i_pattern (~r_seg_s2),
        .o_decode  (w_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an_s1      <= '1;
            r_an_s2      <= '1;
            r_an_prev    <= '1;
            r_seg_s1     <= '1;
            r_seg_s2     <= '1;
            r_seg_prev   <= '1;
            r_stable_cnt <= '0;
        end else begin
            r_an_s1    <= an_n;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
            r_seg_s1   <= seg_n;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            if (w_changed) begin
                r_stable_cnt <= c_CNT_W'(1);
            end else if (r_stable_cnt != c_CNT_MAX) begin
                r_stable_cnt <= r_stable_cnt + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit_val   <= '0;
            r_digit_valid <= '0;
            r_digit_err   <= '0;
            r_mask        <= '0;
            r_frame_done  <= 1'b0;
            r_an_conflict <= 1'b0;
        end else begin
            r_frame_done  <= 1'b0;
            r_an_conflict <= 1'b0;
            if (w_capture && w_multi_an) begin
                r_an_conflict <= 1'b1;
            end else if (w_capture && w_any_an) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (w_an_act[i]) begin
                        if (w_dec.legal) begin
                            r_digit_val[i*BCD_W +: BCD_W] <= w_dec.value;
                            r_digit_valid[i]              <= 1'b1;
                            r_digit_err[i]                <= 1'b0;
                        end else begin
                            r_digit_valid[i] <= 1'b0;
                            r_digit_err[i]   <= !w_dec.blank;
                        end
                    end
                end
                // Completing the frame clears the mask in the same update.
                if (&w_mask_next) begin
                    r_frame_done <= 1'b1;
                    r_mask       <= '0;
                end else begin
                    r_mask <= w_mask_next;
                end
            end
        end
    end

    assign digit_val   = r_digit_val;
    assign digit_valid = r_digit_valid;
    assign digit_err   = r_digit_err;
    assign frame_done  = r_frame_done;
    assign an_conflict = r_an_conflict;

endmodule : seg7_scan_decoder
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Self-checking bench for seg7_scan_decoder. Stimulus drives
//               held bus segments; a reference model predicts the digit state
//               and pulse cycles into queues that a monitor process compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int LAT           = 2 + STABLE_CYCLES;
    localparam logic [10:0] IDLE = 11'h7FF;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic [15:0] digit_val;
    logic [3:0]  digit_valid, digit_err;
    logic        frame_done, an_conflict;

    seg7_scan_decoder #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .digit_val   (digit_val),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .frame_done  (frame_done),
        .an_conflict (an_conflict)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic [3:0]  valid;
        logic [3:0]  err;
        string       tag;
    } chk_t;

    chk_t chk_q[$];
    int   fd_q[$];
    int   cf_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    logic [15:0] m_val   = '0;
    logic [3:0]  m_valid = '0;
    logic [3:0]  m_err   = '0;
    logic [3:0]  m_mask  = '0;
    logic [10:0] prev_pat = IDLE;
    int          last_t = 0;

    logic [6:0] legal_pats [12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                    7'h7D, 7'h07, 7'h27, 7'h7F, 7'h6F, 7'h67};

    // Returns the digit shown, -2 for blank, -1 for anything else.
    function automatic int ref_digit(input logic [6:0] p);
        logic [6:0] canon [10];
        canon = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (p == 7'h00) return -2;
        for (int d = 0; d < 10; d++) if (p == canon[d]) return d;
        if (p == 7'h27) return 7;
        if (p == 7'h67) return 9;
        return -1;
    endfunction

    function automatic int n_low(input logic [3:0] a);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) n++;
        return n;
    endfunction

    function automatic int low_idx(input logic [3:0] a);
        for (int i = 0; i < 4; i++) if (!a[i]) return i;
        return 0;
    endfunction

    function automatic chk_t snap(input int t, input string tag);
        chk_t c;
        c.cyc = t; c.val = m_val; c.valid = m_valid; c.err = m_err; c.tag = tag;
        return c;
    endfunction

    // Drive one bus pattern for len clock edges and predict its effect.
    task automatic drive(input logic [3:0] a, input logic [6:0] s_n, input int len,
                         input string tag);
        int e0, t, idx, d;
        @(posedge clk); #1;
        an_n = a; seg_n = s_n;
        e0 = cyc;
        if (len >= STABLE_CYCLES) begin
            t = e0 + LAT;
            chk_q.push_back(snap(t - 1, {tag, "_pre"}));
            if (n_low(a) > 1) begin
                cf_q.push_back(t);
            end else if (n_low(a) == 1) begin
                idx = low_idx(a);
                d = ref_digit(~s_n);
                if (d >= 0) begin
                    m_val[idx*4 +: 4] = 4'(d);
                    m_valid[idx] = 1'b1;
                    m_err[idx] = 1'b0;
                end else begin
                    m_valid[idx] = 1'b0;
                    m_err[idx] = (d == -1);
                end
                m_mask[idx] = 1'b1;
                if (m_mask == 4'hF) begin
                    fd_q.push_back(t);
                    m_mask = '0;
                end
            end
            chk_q.push_back(snap(t, tag));
            last_t = t;
        end else begin
            t = e0 + len;
            if (t < last_t) t = last_t;
            chk_q.push_back(snap(t, tag));
        end
        prev_pat = {a, s_n};
        repeat (len - 1) @(posedge clk);
    endtask

    // Park the bus on the idle (no anode) pattern and drain all predictions.
    task automatic wait_idle();
        int n = 0;
        if (prev_pat != IDLE) drive(4'hF, 7'h7F, 12, "idle");
        while ((chk_q.size() + fd_q.size() + cf_q.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d predictions still pending, want 0",
                     chk_q.size() + fd_q.size() + cf_q.size());
        end
    endtask

    // Monitor: compares predicted state and pulses on the falling edge.
    initial begin : monitor
        chk_t c;
        logic exp_p;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
                c = chk_q.pop_front();
                checks++;
                if (c.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: check for cycle %0d reached at cycle %0d", c.tag, c.cyc, cyc);
                end else if (digit_val !== c.val || digit_valid !== c.valid || digit_err !== c.err) begin
                    errors++;
                    $display("FAIL %s @%0d: val=%h valid=%b err=%b, want val=%h valid=%b err=%b",
                             c.tag, cyc, digit_val, digit_valid, digit_err, c.val, c.valid, c.err);
                end
            end
            while (fd_q.size() > 0 && fd_q[0] < cyc) begin
                void'(fd_q.pop_front());
                checks++; errors++;
                $display("FAIL frame_done: predicted pulse skipped at cycle %0d", cyc);
            end
            exp_p = (fd_q.size() > 0 && fd_q[0] == cyc);
            if (exp_p) void'(fd_q.pop_front());
            if (exp_p || frame_done !== 1'b0) begin
                checks++;
                if (frame_done !== exp_p) begin
                    errors++;
                    $display("FAIL frame_done @%0d: got %b, want %b", cyc, frame_done, exp_p);
                end
            end
            while (cf_q.size() > 0 && cf_q[0] < cyc) begin
                void'(cf_q.pop_front());
                checks++; errors++;
                $display("FAIL an_conflict: predicted pulse skipped at cycle %0d", cyc);
            end
            exp_p = (cf_q.size() > 0 && cf_q[0] == cyc);
            if (exp_p) void'(cf_q.pop_front());
            if (exp_p || an_conflict !== 1'b0) begin
                checks++;
                if (an_conflict !== exp_p) begin
                    errors++;
                    $display("FAIL an_conflict @%0d: got %b, want %b", cyc, an_conflict, exp_p);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1; an_n = '1; seg_n = '1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk_q.push_back(snap(cyc, "reset_state"));
        last_t = cyc;

        // Single digit: 2 on position 0
        drive(4'b1110, ~7'h5B, 10, "single_2");
        // Partial frame on positions 3 and 2, then reset mid-frame
        drive(4'b0111, ~7'h4F, 12, "partial_3");
        drive(4'b1011, ~7'h27, 12, "partial_7alt");
        wait_idle();
        @(posedge clk); #2;
        reset = 1'b1;
        m_val = '0; m_valid = '0; m_err = '0; m_mask = '0;
        chk_q.push_back(snap(cyc, "reset_mid"));
        an_n = '1; seg_n = '1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        prev_pat = IDLE;
        last_t = cyc;

        // Full scan 1,2,3,4 -> frame_done on the last digit
        drive(4'b1110, ~7'h06, 12, "scan_d0");
        drive(4'b1101, ~7'h5B, 12, "scan_d1");
        drive(4'b1011, ~7'h4F, 12, "scan_d2");
        drive(4'b0111, ~7'h66, 12, "scan_d3");

        // Glitching bus: toggles every 3 clocks, nothing captured
        for (int k = 0; k < 13; k++)
            drive(4'b1110, (k % 2 == 0) ? ~7'h6D : ~7'h7D, 3, "glitch");
        wait_idle();

        // Two anodes low
        drive(4'b1100, ~7'h7F, 12, "conflict");
        // Stability boundary: 7 cycles ignored, 8 cycles captured
        drive(4'b1101, ~7'h67, 7, "hold_7");
        drive(4'b1101, ~7'h07, 8, "hold_8");
        // Legal 5, then illegal 0x49, then blank on position 1
        drive(4'b1101, ~7'h6D, 12, "legal_5");
        drive(4'b1101, ~7'h49, 12, "illegal_49");
        drive(4'b1101, 7'h7F, 12, "blank");
        wait_idle();

        for (int n = 0; n < 60; n++) begin
            logic [3:0] a;
            logic [6:0] p;
            int r;
            do begin
                r = $urandom_range(0, 9);
                if (r < 7) a = ~(4'b0001 << $urandom_range(0, 3));
                else if (r == 7) a = 4'hF;
                else begin
                    do a = 4'($urandom); while (n_low(a) < 2);
                end
                r = $urandom_range(0, 9);
                if (r < 6) p = legal_pats[$urandom_range(0, 11)];
                else if (r == 6) p = 7'h00;
                else p = 7'($urandom);
            end while ({a, ~p} == prev_pat);
            drive(a, ~p, $urandom_range(3, 14), "random");
        end
        wait_idle();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seg7_scan_decoder
`default_nettype wire
